// File: rtl/nes_ctrl_pkg.sv
// Shared types and defaults for the NES system controller.
package nes_ctrl_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK,
        LOAD_REQ,
        LOADING,
        HOLD,
        RUN,
        ERROR
    } seq_state_t;

    localparam int CE_DIV = 4;

    localparam int DEF_DEBOUNCE_CYCLES   = 65536;
    localparam int DEF_LONG_PRESS_CYCLES = 6000000;
    localparam int DEF_NUM_GAMES         = 8;
    localparam int DEF_LOAD_TIMEOUT      = 1 << 24;
    localparam int DEF_RESET_HOLD        = 16;

    function automatic logic [3:0] next_index(input logic [3:0] idx, input int num_games);
        return (int'(idx) >= num_games - 1) ? 4'd0 : idx + 4'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Select-button conditioning: 2-FF sync, debounce, short/long press classification.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES   = 65536,
    parameter int LONG_PRESS_CYCLES = 6000000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic btn_n,
    output logic pressed,
    output logic press_short,
    output logic press_long
);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DUR_W = $clog2(LONG_PRESS_CYCLES + 1);

    logic [1:0]       sync;
    logic [DB_W-1:0]  db_cnt;
    logic [DUR_W-1:0] dur;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync        <= 2'b11;
            db_cnt      <= '0;
            pressed     <= 1'b0;
            dur         <= '0;
            press_short <= 1'b0;
            press_long  <= 1'b0;
        end else begin
            sync        <= {sync[0], btn_n};
            press_short <= 1'b0;
            press_long  <= 1'b0;

            if (!sync[1] == pressed) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                db_cnt  <= '0;
                pressed <= !sync[1];
                // A release after the long threshold already fired stays silent
                if (pressed && dur < DUR_W'(LONG_PRESS_CYCLES - 1))
                    press_short <= 1'b1;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end

            if (!pressed)
                dur <= '0;
            else if (dur != DUR_W'(LONG_PRESS_CYCLES))
                dur <= dur + 1'b1;

            if (pressed && dur == DUR_W'(LONG_PRESS_CYCLES - 1))
                press_long <= 1'b1;
        end
    end

endmodule

// File: rtl/rom_load_sequencer.sv
// NES system controller: PLL lock, ROM load handshake, core reset release,
// 1-in-4 clock enable and select-button game cycling.
module rom_load_sequencer import nes_ctrl_pkg::*; #(
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
    parameter int NUM_GAMES         = DEF_NUM_GAMES,
    parameter int LOAD_TIMEOUT      = DEF_LOAD_TIMEOUT,
    parameter int RESET_HOLD        = DEF_RESET_HOLD
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       btn_n,
    input  logic       load_done,
    output logic       reload,
    output logic [3:0] index,
    output logic       nes_reset,
    output logic       nes_ce,
    output logic       busy,
    output logic       load_error
);
    localparam int CE_W   = $clog2(CE_DIV);
    localparam int TO_W   = $clog2(LOAD_TIMEOUT + 1);
    localparam int HOLD_W = $clog2(RESET_HOLD + 1);

    seq_state_t        state, state_nxt;
    logic [1:0]        lock_sync;
    logic              locked;
    logic [CE_W-1:0]   ce_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              seen_low;
    logic              armed;
    logic              pressed, pressed_q, press_short, press_long;
    logic              released, btn_live;

    btn_debounce #(
        .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
        .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
    ) u_btn (
        .clock      (clock),
        .reset_n    (reset_n),
        .btn_n      (btn_n),
        .pressed    (pressed),
        .press_short(press_short),
        .press_long (press_long)
    );

    assign locked   = lock_sync[1];
    assign released = pressed_q & ~pressed;
    assign btn_live = (state == RUN) || (state == ERROR);

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_LOCK: if (locked) state_nxt = LOAD_REQ;
            LOAD_REQ:  state_nxt = LOADING;
            LOADING: begin
                if (seen_low && load_done)
                    state_nxt = HOLD;
                else if (to_cnt == TO_W'(LOAD_TIMEOUT - 1))
                    state_nxt = ERROR;
            end
            HOLD: if (nes_ce && hold_cnt == HOLD_W'(RESET_HOLD - 1)) state_nxt = RUN;
            RUN: begin
                if (armed && press_short)
                    state_nxt = LOAD_REQ;
                else if (armed && press_long)
                    state_nxt = HOLD;
            end
            ERROR:   if (armed && released) state_nxt = LOAD_REQ;
            default: state_nxt = WAIT_LOCK;
        endcase
        if (!locked)
            state_nxt = WAIT_LOCK;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= WAIT_LOCK;
            lock_sync  <= 2'b00;
            ce_cnt     <= '0;
            nes_ce     <= 1'b0;
            to_cnt     <= '0;
            hold_cnt   <= '0;
            seen_low   <= 1'b0;
            armed      <= 1'b0;
            pressed_q  <= 1'b0;
            reload     <= 1'b0;
            index      <= 4'd0;
            nes_reset  <= 1'b1;
            busy       <= 1'b1;
            load_error <= 1'b0;
        end else begin
            state     <= state_nxt;
            lock_sync <= {lock_sync[0], pll_locked};
            ce_cnt    <= ce_cnt + 1'b1;
            nes_ce    <= (ce_cnt == CE_W'(CE_DIV - 1));
            pressed_q <= pressed;

            if (state == LOAD_REQ) begin
                to_cnt   <= '0;
                seen_low <= 1'b0;
            end else if (state == LOADING) begin
                to_cnt <= to_cnt + 1'b1;
                if (!load_done)
                    seen_low <= 1'b1;
            end

            if (state != HOLD)
                hold_cnt <= '0;
            else if (nes_ce)
                hold_cnt <= hold_cnt + 1'b1;

            // Only presses that begin while the button is live may act
            if (!btn_live)
                armed <= 1'b0;
            else if (pressed && !pressed_q)
                armed <= 1'b1;

            if (state == RUN && state_nxt == LOAD_REQ)
                index <= next_index(index, NUM_GAMES);

            reload     <= (state_nxt == LOAD_REQ);
            nes_reset  <= (state_nxt != RUN);
            busy       <= (state_nxt != RUN);
            load_error <= (state_nxt == ERROR);
        end
    end

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Directed bench for rom_load_sequencer with a per-cycle output model.
module tb_rom_load_sequencer;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       btn_n = 1'b1;
    logic       load_done = 1'b1;
    logic       reload, nes_reset, nes_ce, busy, load_error;
    logic [3:0] index;

    int         pass_cnt = 0, total_cnt = 0;
    int         edges = 0, reload_cnt = 0;
    logic [3:0] exp_index = 4'd0;
    logic       prev_reload = 1'b0;

    rom_load_sequencer #(
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(32),
        .NUM_GAMES        (3),
        .LOAD_TIMEOUT     (100),
        .RESET_HOLD       (2)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .pll_locked(pll_locked),
        .btn_n     (btn_n),
        .load_done (load_done),
        .reload    (reload),
        .index     (index),
        .nes_reset (nes_reset),
        .nes_ce    (nes_ce),
        .busy      (busy),
        .load_error(load_error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Rising edges since reset release: the enable is high after every 4th.
    always @(posedge clock) begin
        if (reset_n) edges = edges + 1;
        else         edges = 0;
    end

    always @(negedge clock) begin
        if (!reset_n) begin
            chk("reset_outputs", {reload, index, nes_reset, nes_ce, busy, load_error},
                {1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0});
            prev_reload = 1'b0;
        end else begin
            chk("nes_ce_period", nes_ce, (edges > 0 && edges % 4 == 0));
            chk("busy_eq_nes_reset", busy, nes_reset);
            if (reload) begin
                reload_cnt++;
                chk("reload_index", index, exp_index);
                chk("reload_single_cycle", prev_reload, 0);
            end
            prev_reload = reload;
        end
    end

    task automatic wait_reload(input int max, output bit got);
        got = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clock);
            if (reload) begin
                got = 1;
                break;
            end
        end
    endtask

    task automatic count_hold(input int max, output int ce_n, output bit fell);
        ce_n = 0;
        fell = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clock);
            if (!nes_reset) begin
                fell = 1;
                break;
            end
            if (nes_ce) ce_n++;
        end
    endtask

    task automatic finish_load(input string nm);
        int ce_n;
        bit fell;
        @(negedge clock);
        load_done = 1'b0;
        repeat (3) @(negedge clock);
        load_done = 1'b1;
        count_hold(40, ce_n, fell);
        chk({nm, "_run_reached"}, fell, 1);
        chk({nm, "_hold_ce"}, ce_n, 2);
    endtask

    task automatic press(input int n);
        btn_n = 1'b0;
        repeat (n) @(negedge clock);
        btn_n = 1'b1;
    endtask

    task automatic next_exp();
        exp_index = 4'((int'(exp_index) + 1) % 3);
    endtask

    initial begin
        int first, ce_n, k, r0;
        bit fell, got;
        int t2_exp[3];
        t2_exp = '{1, 2, 0};

        // 1: power-up, stale load_done, hold release
        pll_locked = 1'b1;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("t1_reload_edge2", reload, 0);
        @(negedge clock);
        chk("t1_reload_edge3", reload, 1);
        chk("t1_ce_edge3", nes_ce, 0);
        @(negedge clock);
        chk("t1_ce_edge4", nes_ce, 1);
        chk("t1_reload_gone", reload, 0);
        repeat (20) @(negedge clock);
        chk("t1_one_reload", reload_cnt, 1);
        chk("t1_stale_done_ignored", busy, 1);
        load_done = 1'b0;
        @(negedge clock);
        load_done = 1'b1;
        count_hold(40, ce_n, fell);
        chk("t1_hold_released", fell, 1);
        chk("t1_hold_ce_pulses", ce_n, 2);
        chk("t1_busy_run", busy, 0);

        // 2: three short presses cycle the slot
        for (int p = 0; p < 3; p++) begin
            r0 = reload_cnt;
            next_exp();
            press(10);
            wait_reload(30, got);
            chk("t2_reload_seen", got, 1);
            chk("t2_index", index, t2_exp[p]);
            finish_load("t2");
            chk("t2_one_reload", reload_cnt - r0, 1);
        end

        // 3: long press re-holds the core without reload
        r0 = reload_cnt;
        first = -1;
        ce_n = 0;
        fell = 0;
        btn_n = 1'b0;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clock);
            if (c == 40) btn_n = 1'b1;
            if (nes_reset && !fell) begin
                if (first < 0) first = c;
                if (nes_ce) ce_n++;
            end else if (first >= 0 && !fell) begin
                fell = 1;
            end
        end
        chk("t3_hold_start_window", (first >= 32 && first <= 40), 1);
        chk("t3_hold_released", fell, 1);
        chk("t3_hold_ce_pulses", ce_n, 2);
        chk("t3_no_reload", reload_cnt - r0, 0);
        chk("t3_index", index, 0);
        chk("t3_busy_run", busy, 0);

        // 4: load timeout and retry
        r0 = reload_cnt;
        next_exp();
        press(10);
        wait_reload(30, got);
        chk("t4_reload_seen", got, 1);
        k = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clock);
            k++;
            if (load_error) break;
        end
        chk("t4_timeout_cycles", k, 101);
        chk("t4_load_error", load_error, 1);
        press(10);
        wait_reload(30, got);
        chk("t4_retry_reload", got, 1);
        chk("t4_retry_index", index, 1);
        chk("t4_error_cleared", load_error, 0);
        finish_load("t4");
        chk("t4_reloads", reload_cnt - r0, 2);

        // 5: glitches, and a press during LOADING
        r0 = reload_cnt;
        for (int g = 1; g <= 3; g++) begin
            btn_n = 1'b0;
            repeat (g) @(negedge clock);
            btn_n = 1'b1;
            repeat (6) @(negedge clock);
        end
        repeat (15) @(negedge clock);
        chk("t5_glitch_no_reload", reload_cnt - r0, 0);
        chk("t5_glitch_index", index, 1);
        next_exp();
        press(10);
        wait_reload(30, got);
        chk("t5_reload_seen", got, 1);
        press(10);
        repeat (12) @(negedge clock);
        chk("t5_loading_press_ignored", reload_cnt - r0, 1);
        finish_load("t5");
        repeat (20) @(negedge clock);
        chk("t5_no_late_reload", reload_cnt - r0, 1);
        chk("t5_index", index, 2);

        // 6: lock loss and asynchronous reset mid-load
        pll_locked = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("t6_lock_lat2", nes_reset, 0);
        @(negedge clock);
        chk("t6_lock_lat3", nes_reset, 1);
        r0 = reload_cnt;
        pll_locked = 1'b1;
        wait_reload(6, got);
        chk("t6_relock_reload", got, 1);
        chk("t6_relock_index", index, 2);
        finish_load("t6");
        next_exp();
        press(10);
        wait_reload(30, got);
        chk("t6_wrap_reload", got, 1);
        finish_load("t6w");
        next_exp();
        press(10);
        wait_reload(30, got);
        chk("t6_pre_reset_reload", got, 1);
        chk("t6_pre_reset_index", index, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_async_reset", {reload, index, nes_reset, busy, load_error},
            {1'b0, 4'd0, 1'b1, 1'b1, 1'b0});
        exp_index = 4'd0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        r0 = reload_cnt;
        wait_reload(6, got);
        chk("t6_post_reset_reload", got, 1);
        finish_load("t6r");
        chk("t6_post_reset_index", index, 0);
        chk("t6_post_reset_reloads", reload_cnt - r0, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
